// File: rtl/key_debounce_bank.sv
// Multi-channel push-button conditioner: two-flop synchroniser, debounced level,
// press/release pulses, long-press pulse and optional auto-repeat per channel.
module key_debounce_bank #(
  parameter int N_KEYS          = 4,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int LONG_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_KEYS-1:0] i_keys,
  input  logic [N_KEYS-1:0] i_repeat_en,
  output logic [N_KEYS-1:0] o_level,
  output logic [N_KEYS-1:0] o_press,
  output logic [N_KEYS-1:0] o_release,
  output logic [N_KEYS-1:0] o_long,
  output logic [N_KEYS-1:0] o_repeat,
  output logic              o_any_press
);

  // state   | meaning
  // IDLE    | debounced level is released
  // PRESSED | pressed, counting towards the long-press pulse
  // HELD    | long press reached, auto-repeat period running while enabled
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } state_e;

  localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [DB_W-1:0]   DB_TC   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_TC = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REP_TC  = HOLD_W'(REPEAT_CYCLES - 1);

  localparam logic [N_KEYS-1:0] RELEASED_RAW = {N_KEYS{ACTIVE_LOW}};

  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;
  logic [N_KEYS-1:0] pressed_w;
  logic [N_KEYS-1:0] rise_w;
  logic              any_press_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= RELEASED_RAW;
      sync2_q <= RELEASED_RAW;
    end else begin
      sync1_q <= i_keys;
      sync2_q <= sync1_q;
    end
  end

  assign pressed_w = sync2_q ^ RELEASED_RAW;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    logic [DB_W-1:0]   db_cnt_q;
    logic [HOLD_W-1:0] hold_q;
    logic              level_q;
    logic              press_q;
    logic              release_q;
    logic              long_q;
    logic              repeat_q;
    state_e            state_q;
    logic              differ_w;
    logic              accept_w;

    assign differ_w  = pressed_w[g] != level_q;
    assign accept_w  = differ_w && (db_cnt_q == DB_TC);
    assign rise_w[g] = accept_w && !level_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        db_cnt_q  <= '0;
        hold_q    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
        state_q   <= ST_IDLE;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;

        // Any sample agreeing with the current level restarts the debounce window.
        if (!differ_w || accept_w) begin
          db_cnt_q <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + 1'b1;
        end

        if (accept_w) begin
          level_q <= !level_q;
        end

        // Release acceptance wins over any long/repeat terminal count on the same edge.
        if (accept_w && level_q) begin
          release_q <= 1'b1;
          hold_q    <= '0;
          state_q   <= ST_IDLE;
        end else begin
          case (state_q)
            ST_IDLE: begin
              if (accept_w) begin
                press_q <= 1'b1;
                hold_q  <= '0;
                state_q <= ST_PRESSED;
              end
            end
            ST_PRESSED: begin
              if (hold_q == LONG_TC) begin
                long_q  <= 1'b1;
                hold_q  <= '0;
                state_q <= ST_HELD;
              end else begin
                hold_q <= hold_q + 1'b1;
              end
            end
            ST_HELD: begin
              if (!i_repeat_en[g]) begin
                hold_q <= '0;
              end else if (hold_q == REP_TC) begin
                repeat_q <= 1'b1;
                hold_q   <= '0;
              end else begin
                hold_q <= hold_q + 1'b1;
              end
            end
            default: begin
              hold_q  <= '0;
              state_q <= ST_IDLE;
            end
          endcase
        end
      end
    end

    assign o_level[g]   = level_q;
    assign o_press[g]   = press_q;
    assign o_release[g] = release_q;
    assign o_long[g]    = long_q;
    assign o_repeat[g]  = repeat_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      any_press_q <= 1'b0;
    end else begin
      any_press_q <= |rise_w;
    end
  end

  assign o_any_press = any_press_q;

endmodule

// File: tb/tb_key_debounce_bank.sv
// Bench for key_debounce_bank: directed sequences, a hold-length table and
// randomized key activity checked against a history-based reference model.
module tb_key_debounce_bank;
  localparam int NK = 4;
  localparam int DB = 4;
  localparam int LC = 20;
  localparam int RC = 8;

  logic          clk = 1'b0;
  logic          i_rst_n = 1'b1;
  logic [NK-1:0] i_keys = 4'hF;
  logic [NK-1:0] i_repeat_en = 4'h0;
  logic [NK-1:0] o_level, o_press, o_release, o_long, o_repeat;
  logic          o_any_press;

  key_debounce_bank #(
    .N_KEYS(NK), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES(LC), .REPEAT_CYCLES(RC)
  ) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_keys(i_keys), .i_repeat_en(i_repeat_en),
    .o_level(o_level), .o_press(o_press), .o_release(o_release),
    .o_long(o_long), .o_repeat(o_repeat), .o_any_press(o_any_press)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // reference model: level flips once the last DB synchronised samples all disagree with it
  bit [NK-1:0] m_s1, m_s2, m_level, e_press, e_rel, e_long, e_rep;
  bit          e_any;
  bit [DB-1:0] m_hist [NK];
  int          m_nval [NK];
  int          m_ptime[NK];
  bit          m_longd[NK];
  int          m_enrun[NK];
  int          m_now;

  int n_press[NK], n_rel[NK], n_long[NK], n_rep[NK];
  int press_at[NK], rel_at[NK], long_at[NK];
  bit any_seen;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (step %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_s1 = '1; m_s2 = '1; m_level = '0;
    e_press = '0; e_rel = '0; e_long = '0; e_rep = '0; e_any = 1'b0;
    for (int c = 0; c < NK; c++) begin
      m_hist[c] = '0; m_nval[c] = 0; m_longd[c] = 1'b0; m_enrun[c] = 0; m_ptime[c] = 0;
    end
  endtask

  task automatic model_edge(input bit [NK-1:0] keys, input bit [NK-1:0] en);
    bit [NK-1:0] p;
    p = ~m_s2;
    m_s2 = m_s1;
    m_s1 = keys;
    m_now++;
    e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
    for (int c = 0; c < NK; c++) begin
      m_hist[c] = {m_hist[c][DB-2:0], p[c]};
      if (m_nval[c] < DB) m_nval[c]++;
      if (m_nval[c] == DB && m_hist[c] == {DB{~m_level[c]}}) begin
        if (!m_level[c]) begin
          m_level[c] = 1'b1; e_press[c] = 1'b1;
          m_ptime[c] = m_now; m_longd[c] = 1'b0; m_enrun[c] = 0;
        end else begin
          m_level[c] = 1'b0; e_rel[c] = 1'b1;
        end
      end else if (m_level[c] && !m_longd[c] && m_now == m_ptime[c] + LC) begin
        e_long[c] = 1'b1; m_longd[c] = 1'b1; m_enrun[c] = 0;
      end else if (m_level[c] && m_longd[c]) begin
        if (en[c]) begin
          m_enrun[c]++;
          if (m_enrun[c] == RC) begin
            e_rep[c] = 1'b1; m_enrun[c] = 0;
          end
        end else begin
          m_enrun[c] = 0;
        end
      end
    end
    e_any = |e_press;
  endtask

  task automatic check_model();
    chk("level",   int'(o_level),     int'(m_level));
    chk("press",   int'(o_press),     int'(e_press));
    chk("release", int'(o_release),   int'(e_rel));
    chk("long",    int'(o_long),      int'(e_long));
    chk("repeat",  int'(o_repeat),    int'(e_rep));
    chk("any",     int'(o_any_press), int'(e_any));
  endtask

  task automatic step();
    logic [NK-1:0] kb, eb;
    logic rb;
    kb = i_keys; eb = i_repeat_en; rb = i_rst_n;
    @(posedge clk);
    #1;
    cyc++;
    if (rb) model_edge(kb, eb);
    check_model();
    for (int c = 0; c < NK; c++) begin
      if (o_press[c])   begin n_press[c]++; press_at[c] = cyc; end
      if (o_release[c]) begin n_rel[c]++;   rel_at[c]   = cyc; end
      if (o_long[c])    begin n_long[c]++;  long_at[c]  = cyc; end
      if (o_repeat[c])  n_rep[c]++;
    end
    if (o_level != 0 || o_press != 0 || o_release != 0 || o_long != 0 ||
        o_repeat != 0 || o_any_press) any_seen = 1'b1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_counts();
    for (int c = 0; c < NK; c++) begin
      n_press[c] = 0; n_rel[c] = 0; n_long[c] = 0; n_rep[c] = 0;
      press_at[c] = -1; rel_at[c] = -1; long_at[c] = -1;
    end
    any_seen = 1'b0;
  endtask

  task automatic set_reset(input logic v);
    i_rst_n = v;
    if (!v) begin
      #1;
      model_reset();
      check_model();
    end
  endtask

  typedef struct {
    int ch;
    int hold;
    bit en;
    int x_press;
    int x_long;
    int x_rep;
  } vec_t;

  vec_t vt[8];

  initial begin
    int c0;
    bit [NK-1:0] kb, gl;
    int dur[NK];

    vt[0] = '{2, 60, 1'b1, 1, 1, 4};  // release coincides with 5th repeat terminal
    vt[1] = '{3, 12, 1'b0, 1, 0, 0};
    vt[2] = '{3, 20, 1'b0, 1, 0, 0};  // release coincides with long terminal
    vt[3] = '{1, 21, 1'b1, 1, 1, 0};
    vt[4] = '{0, 29, 1'b1, 1, 1, 1};
    vt[5] = '{0, 40, 1'b0, 1, 1, 0};
    vt[6] = '{2,  5, 1'b1, 1, 0, 0};
    vt[7] = '{1,  3, 1'b1, 0, 0, 0};

    model_reset();
    m_now = 0;
    clear_counts();

    // reset with all keys released
    #2;
    i_keys = 4'hF;
    set_reset(1'b0);
    steps(3);
    chk("rst_level_zero", int'(o_level), 0);
    set_reset(1'b1);
    clear_counts();
    steps(50);
    chk("idle_no_activity", int'(any_seen), 0);

    // single press on key 0: accepted on the 6th edge after the raw change
    clear_counts();
    i_keys[0] = 1'b0;
    steps(5);
    chk("k0_no_early_press", n_press[0], 0);
    step();
    chk("k0_press", int'(o_press), 4'b0001);
    chk("k0_level", int'(o_level), 4'b0001);
    chk("k0_any",   int'(o_any_press), 1);
    step();
    chk("k0_press_one_cycle", int'(o_press), 0);
    i_keys[0] = 1'b1;
    c0 = cyc;
    steps(10);
    chk("k0_release_latency", rel_at[0] - c0, 6);
    chk("k0_release_count", n_rel[0], 1);

    // bounce on key 1: alternate-cycle toggling, then runs of 3
    clear_counts();
    for (int i = 0; i < 12; i++) begin
      i_keys[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
      step();
    end
    i_keys[1] = 1'b1;
    steps(10);
    for (int r = 0; r < 4; r++) begin
      i_keys[1] = 1'b0; steps(3);
      i_keys[1] = 1'b1; steps(3);
    end
    steps(8);
    chk("bounce_no_press", n_press[1], 0);
    chk("bounce_no_level", int'(any_seen), 0);

    // hold-length table
    for (int t = 0; t < 8; t++) begin
      clear_counts();
      i_repeat_en[vt[t].ch] = vt[t].en;
      i_keys[vt[t].ch] = 1'b0;
      steps(vt[t].hold);
      i_keys[vt[t].ch] = 1'b1;
      c0 = cyc;
      steps(30);
      chk($sformatf("tbl%0d_press", t),   n_press[vt[t].ch], vt[t].x_press);
      chk($sformatf("tbl%0d_release", t), n_rel[vt[t].ch],   vt[t].x_press);
      chk($sformatf("tbl%0d_long", t),    n_long[vt[t].ch],  vt[t].x_long);
      chk($sformatf("tbl%0d_repeat", t),  n_rep[vt[t].ch],   vt[t].x_rep);
      if (vt[t].x_press != 0) begin
        chk($sformatf("tbl%0d_rel_latency", t), rel_at[vt[t].ch] - c0, 6);
        chk($sformatf("tbl%0d_held_span", t), rel_at[vt[t].ch] - press_at[vt[t].ch], vt[t].hold);
      end
      if (vt[t].x_long != 0)
        chk($sformatf("tbl%0d_long_offset", t), long_at[vt[t].ch] - press_at[vt[t].ch], LC);
      i_repeat_en = '0;
    end

    // repeat enable dropped in HELD: full period after re-enable
    clear_counts();
    i_repeat_en[2] = 1'b1;
    i_keys[2] = 1'b0;
    steps(6 + LC + 3);
    i_repeat_en[2] = 1'b0;
    steps(10);
    i_repeat_en[2] = 1'b1;
    c0 = cyc;
    steps(RC + 2);
    chk("reen_one_repeat", n_rep[2], 1);
    i_keys[2] = 1'b1;
    i_repeat_en = '0;
    steps(12);

    // simultaneous press on keys 0 and 2, then reset while held
    clear_counts();
    i_keys[0] = 1'b0; i_keys[2] = 1'b0;
    steps(6);
    chk("dual_press", int'(o_press), 4'b0101);
    chk("dual_any", int'(o_any_press), 1);
    steps(10);
    chk("dual_level_held", int'(o_level), 4'b0101);
    set_reset(1'b0);
    chk("rst_level_now", int'(o_level), 0);
    chk("rst_no_release", int'(o_release), 0);
    steps(2);
    set_reset(1'b1);
    clear_counts();
    steps(5);
    chk("rst_reaccept_not_early", n_press[0] + n_press[2], 0);
    step();
    chk("rst_reaccept_press", int'(o_press), 4'b0101);
    i_keys = 4'hF;
    steps(12);

    // randomized activity against the reference model
    kb = 4'hF;
    for (int c = 0; c < NK; c++) dur[c] = $urandom_range(1, 70);
    for (int n = 0; n < 4000; n++) begin
      gl = '0;
      for (int c = 0; c < NK; c++) begin
        if (dur[c] == 0) begin
          kb[c] = ~kb[c];
          dur[c] = $urandom_range(1, 70);
        end else begin
          dur[c]--;
        end
        if ($urandom_range(0, 15) == 0) gl[c] = 1'b1;
        if ($urandom_range(0, 29) == 0) i_repeat_en[c] = ~i_repeat_en[c];
      end
      i_keys = kb ^ gl;
      if (n % 1700 == 1699) begin
        set_reset(1'b0);
        steps(2);
        set_reset(1'b1);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
